// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM states and the access legality check.
package load_store_unit_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MEM_WORDS_DEF = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WSTORE = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // Rejects illegal encodings, misalignment and word indices past the memory.
  function automatic logic access_fault(input logic              write,
                                        input logic [2:0]        f3,
                                        input logic [DATA_W-1:0] addr,
                                        input int unsigned       mem_words);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr[0];
      F3_W:        bad = (addr[1:0] != 2'b00);
      default:     bad = 1'b1;
    endcase
    if (write && !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W))) bad = 1'b1;
    if (32'(addr[DATA_W-1:2]) >= mem_words) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals between execute stage, LSU and memory.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: load byte/half extraction with extension, and
// sub-word store merge into a previously read word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]        f3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {byte_off, 3'b000};

  always_comb begin
    load_data_c = '0;
    case (f3)
      F3_B:    load_data_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_c = rdata;
      F3_BU:   load_data_c = {24'h0, shifted[7:0]};
      F3_HU:   load_data_c = {16'h0, shifted[15:0]};
      default: load_data_c = '0;
    endcase
  end

  // Only the addressed lane takes store data; the rest keep the read word.
  always_comb begin
    merge_data_c = rdata;
    case (f3)
      F3_B: begin
        case (byte_off)
          2'd0:    merge_data_c = {rdata[31:8], wdata[7:0]};
          2'd1:    merge_data_c = {rdata[31:16], wdata[7:0], rdata[7:0]};
          2'd2:    merge_data_c = {rdata[31:24], wdata[7:0], rdata[15:0]};
          default: merge_data_c = {wdata[7:0], rdata[23:0]};
        endcase
      end
      F3_H:    merge_data_c = byte_off[1] ? {wdata[15:0], rdata[15:0]}
                                          : {rdata[31:16], wdata[15:0]};
      F3_W:    merge_data_c = wdata;
      default: merge_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word accesses into word memory cycles,
// with read-modify-write for sub-word stores and fault detection.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic clk,
  input  logic reset,
  load_store_unit_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fault_c;
  logic              accept_c;
  logic [DATA_W-1:0] load_data_c, merge_data_c;

  logic              req_ready_q, resp_valid_q, resp_fault_q, mem_read_q, mem_write_q;
  logic [DATA_W-1:0] resp_rdata_q, mem_addr_q, mem_wdata_q;
  logic              req_ready_d, resp_valid_d, resp_fault_d, mem_read_d, mem_write_d;
  logic [DATA_W-1:0] resp_rdata_d, mem_addr_d, mem_wdata_d;

  assign accept_c = (state_q == IDLE) && bus.req_valid;
  assign fault_c  = access_fault(bus.req_write, bus.req_funct3, bus.req_addr, MEM_WORDS);

  lsu_lane_align u_lane_align (
    .f3           (f3_q),
    .byte_off     (off_q),
    .rdata        (bus.mem_rdata),
    .wdata        (wdata_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (fault_c)                         state_d = RESP;
          else if (!bus.req_write)             state_d = LOAD;
          else if (bus.req_funct3 == F3_W)     state_d = WSTORE;
          else                                 state_d = RMW_RD;
        end
      end
      LOAD, WSTORE, RMW_WR: state_d = RESP;
      RMW_RD:               state_d = RMW_WR;
      RESP:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_read_d   = (state_d == LOAD) || (state_d == RMW_RD);
    mem_write_d  = (state_d == WSTORE) || (state_d == RMW_WR);
    resp_fault_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (fault_c) begin
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_addr_d = {2'b00, bus.req_addr[DATA_W-1:2]};
            if (bus.req_write && (bus.req_funct3 == F3_W)) mem_wdata_d = bus.req_wdata;
          end
        end
      end
      LOAD:           resp_rdata_d = load_data_c;
      RMW_RD:         mem_wdata_d  = merge_data_c;
      WSTORE, RMW_WR: resp_rdata_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      f3_q    <= bus.req_funct3;
      off_q   <= bus.req_addr[1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory (64 x 32-bit, word index on its address port) and is driven by the execute stage.
- Turns byte, halfword and word loads and stores (RISC-V funct3 encoding, byte addresses) into word-level memory accesses.
- Returns sign- or zero-extended load data.
- Performs sub-word stores as read-modify-write sequences.
- Flags misaligned, out-of-range and illegal accesses.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; word indices at or above this value fault.
- DATA_W, 32, data and address width; fixed at 32 for RV32.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  unit is idle and can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word data taken from the low bits
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  qualified by resp_valid; access rejected
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_addr  out  32  word index, {2'b00, req_addr[31:2]}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset state: IDLE. Outputs at reset: req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- mem_* outputs are decoded from registered state and latched fields only; there is no combinational path from req_* to mem_*.
- State IDLE:
  - req_ready=1.
  - On rising edge with req_valid=1, latch write, funct3, addr, wdata, then evaluate the access.
  - Fault if any of the following holds: funct3 in {011,110,111}; store with funct3 not in {000,001,010}; H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
  - Fault -> RESP with fault=1; no memory access at all.
  - Otherwise: load -> LOAD; SW -> WSTORE; SB/SH -> RMW_RD.
- State LOAD:
  - mem_read=1, mem_addr=index.
  - At the edge, capture mem_rdata, select the byte/half by addr[1:0], extend (signed for B/H, zero for BU/HU), then -> RESP.
- State WSTORE: mem_write=1, mem_wdata=wdata; the memory commits at this edge; -> RESP.
- State RMW_RD: mem_read=1; capture mem_rdata into a merge register; -> RMW_WR.
- State RMW_WR:
  - mem_write=1, mem_wdata = captured word with the target lane replaced.
  - SB replaces byte lane addr[1:0] with wdata[7:0]; SH replaces halfword lane addr[1] with wdata[15:0]; other lanes are unchanged.
  - -> RESP.
- State RESP:
  - resp_valid=1 for exactly one cycle, with resp_fault and resp_rdata valid; -> IDLE.
  - resp_rdata holds its value until the next RESP.
- Latency from the accept edge to resp_valid high: fault 1 cycle, SW 2, load 2, SB/SH 3.
- req_ready=0 in all states except IDLE. No pipelining: one request in flight.
- Requests presented while not ready are ignored; the requester must hold them.
- Reset mid-operation: state returns to IDLE immediately and mem_write drops asynchronously. A read-modify-write aborted in RMW_RD writes nothing. No response is issued for the aborted request.
- mem_read and mem_write are never high in the same cycle.

Decomposition:
- Shared package holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum (IDLE, LOAD, WSTORE, RMW_RD, RMW_WR, RESP);
  - MEM_WORDS default.
- One combinational sub-module, lsu_lane_align: load extract/extend plus store lane merge, parameterised by funct3 and addr[1:0].

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF -> mem_write high one cycle with mem_addr=4 and mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept, fault=0.
- LB from addr=0x13 with the word holding 0xDEADBEEF -> resp_rdata=0xFFFFFFDE. LBU from addr=0x13 -> 0x000000DE. LH from addr=0x10 -> 0xFFFFBEEF. LHU from addr=0x12 -> 0x0000DEAD.
- SB addr=0x11 wdata=0x000000AA, word 0xDEADBEEF -> mem_read cycle, then mem_write with 0xDEADAAEF; resp 3 cycles after accept.
- SH addr=0x11 -> resp_fault=1 after 1 cycle, mem_write never asserted. LW addr=0x100 (index 64) -> fault. funct3=011 -> fault.
- Assert reset during RMW_RD of SB addr=0x20 -> mem_write stays 0, memory word unchanged, req_ready=1, no resp_valid.
- Back-to-back requests with req_valid held high -> each accepted only when req_ready=1; responses in order, one per request.
